// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and the flag-field layout of a queued {res, flags} entry.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_ADC = 3'b110,
        OP_SBC = 3'b111
    } op_e;

    // Flags occupy the low nibble of an entry; the result sits above them.
    localparam int FLG_N = 0;
    localparam int FLG_V = 1;
    localparam int FLG_C = 2;
    localparam int FLG_Z = 3;
    localparam int FLG_W = 4;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result queue: DEPTH entries of W bits, head entry visible combinationally.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: o_full blocks pushes; no pass-through when full.
module alu_result_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    // Storage is cleared too so the head outputs read zero out of reset.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_dat;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dat   = r_mem[r_rptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_pipe.sv
// Registered multi-op ALU with carry chaining; ALU_SAT_EN enables signed saturation.
// Latency: result at queue head one cycle after accept (when queue empty).
// Backpressure: in_ready drops while the DEPTH-entry result queue is full.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             elk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             n
);
`ifdef ALU_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic                   r_cy;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [WIDTH-1:0]       w_b_eff;
    logic                   w_cin;
    logic [WIDTH:0]         w_sum;
    logic                   w_ov;
    logic [WIDTH-1:0]       w_res;
    logic                   w_c;
    logic                   w_v;
    logic [WIDTH+FLG_W-1:0] w_entry;
    logic [WIDTH+FLG_W-1:0] w_head;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_b_eff = opB;
        w_cin   = 1'b0;
        case (sel)
            OP_SUB: begin
                w_b_eff = ~opB;
                w_cin   = 1'b1;
            end
            OP_ADC: w_cin = r_cy;
            OP_SBC: begin
                w_b_eff = ~opB;
                w_cin   = r_cy;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, opA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    assign w_ov  = (opA[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != opA[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (sel)
            OP_AND: w_res = opA & opB;
            OP_OR:  w_res = opA | opB;
            OP_XOR: w_res = opA ^ opB;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            default: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_ov;
                // Clamp toward the sign of A; carry keeps the unsaturated value.
                if (SAT_EN && w_ov) begin
                    w_res = opA[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        endcase
    end

    always_comb begin
        w_entry                      = '0;
        w_entry[FLG_W +: WIDTH]      = w_res;
        w_entry[FLG_Z]               = (w_res == '0);
        w_entry[FLG_C]               = w_c;
        w_entry[FLG_V]               = w_v;
        w_entry[FLG_N]               = w_res[WIDTH-1];
    end

    always_ff @(posedge elk or negedge rst_n) begin
        if (!rst_n) begin
            r_cy <= 1'b0;
        end else if (w_push && is_arith(sel)) begin
            r_cy <= w_c;
        end
    end

    alu_result_fifo #(
        .W     (WIDTH + FLG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk (elk),
        .arst_n   (rst_n),
        .i_push   (w_push),
        .i_dat    (w_entry),
        .i_pop    (w_pop),
        .o_dat    (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign res       = w_head[FLG_W +: WIDTH];
    assign z         = w_head[FLG_Z];
    assign c         = w_head[FLG_C];
    assign v         = w_head[FLG_V];
    assign n         = w_head[FLG_N];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32, DEPTH=2); head compared as {res,z,c,v,n}.
module tb_alu_pipe;
    logic        elk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        n;

    int tests;
    int fails;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, ADC = 3'b110, SBC = 3'b111;

    alu_pipe #(.WIDTH(32), .DEPTH(2)) dut (
        .elk       (elk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .z         (z),
        .c         (c),
        .v         (v),
        .n         (n)
    );

    initial elk = 1'b0;
    always #5 elk = ~elk;

    task automatic push_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        @(negedge elk);
        sel = s; opA = a; opB = b; in_valid = 1'b1;
        @(posedge elk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge elk);
        out_ready = 1'b1;
        @(posedge elk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge elk); #1;
        tests++;
        if ({out_valid, in_ready, res, z, c, v, n} !== {1'b0, 1'b1, 36'h0}) begin
            fails++;
            $display("FAIL reset_state got vld=%b rdy=%b %h/%b%b%b%b want vld=0 rdy=1 all zero",
                     out_valid, in_ready, res, z, c, v, n);
        end
        push_op(ADC, 32'h0, 32'h0);
        tests++;
        if ({out_valid, res, z, c, v, n} !== {1'b1, 32'h0, 4'b1000}) begin
            fails++;
            $display("FAIL reset_adc got vld=%b %h/%b%b%b%b want vld=1 00000000/1000",
                     out_valid, res, z, c, v, n);
        end
        pop_one();
    endtask

    task automatic test_sub();
        logic [2:0]  s   [3] = '{SUB, SUB, SUB};
        logic [31:0] a   [3] = '{32'd10, 32'd2, 32'd0};
        logic [31:0] b   [3] = '{32'd2, 32'd2, 32'd1};
        logic [35:0] exp [3] = '{{32'd8, 4'b0100}, {32'd0, 4'b1100}, {32'hFFFF_FFFF, 4'b0001}};
        for (int i = 0; i < 3; i++) begin
            push_op(s[i], a[i], b[i]);
            tests++;
            if ({res, z, c, v, n} !== exp[i]) begin
                fails++;
                $display("FAIL sub_%0d got %h/%b%b%b%b want %h", i, res, z, c, v, n, exp[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_overflow();
        logic [35:0] exp;
`ifdef ALU_SAT_EN
        exp = {32'h7FFF_FFFF, 4'b0010};
`else
        exp = {32'h8000_0000, 4'b0011};
`endif
        push_op(ADD, 32'h7FFF_FFFF, 32'h1);
        tests++;
        if ({res, z, c, v, n} !== exp) begin
            fails++;
            $display("FAIL add_overflow got %h/%b%b%b%b want %h", res, z, c, v, n, exp);
        end
        pop_one();
    endtask

    task automatic test_logic();
        logic [2:0]  s   [4] = '{AND_, OR_, SLT, SLT};
        logic [31:0] a   [4] = '{32'h0000_F0F0, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'h1};
        logic [31:0] b   [4] = '{32'h0000_FF00, 32'h0000_FF00, 32'h1, 32'hFFFF_FFFF};
        logic [35:0] exp [4] = '{{32'h0000_F000, 4'b0000}, {32'h0000_FFF0, 4'b0000},
                                 {32'h1, 4'b0000}, {32'h0, 4'b1000}};
        for (int i = 0; i < 4; i++) begin
            push_op(s[i], a[i], b[i]);
            tests++;
            if ({res, z, c, v, n} !== exp[i]) begin
                fails++;
                $display("FAIL logic_%0d got %h/%b%b%b%b want %h", i, res, z, c, v, n, exp[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_back_to_back();
        // ADD then ADC on consecutive edges: ADC must see the fresh carry.
        @(negedge elk);
        sel = ADD; opA = 32'hFFFF_FFFF; opB = 32'h1; in_valid = 1'b1;
        @(negedge elk);
        sel = ADC; opA = 32'h0; opB = 32'h0;
        @(posedge elk);
        #1 in_valid = 1'b0;
        tests++;
        if ({res, z, c, v, n} !== {32'h0, 4'b1100}) begin
            fails++;
            $display("FAIL chain_add got %h/%b%b%b%b want 00000000/1100", res, z, c, v, n);
        end
        pop_one();
        tests++;
        if ({out_valid, res, z, c, v, n} !== {1'b1, 32'h1, 4'b0000}) begin
            fails++;
            $display("FAIL chain_adc got vld=%b %h/%b%b%b%b want vld=1 00000001/0000",
                     out_valid, res, z, c, v, n);
        end
        pop_one();
    endtask

    task automatic test_carry_hold();
        logic [2:0]  s   [7] = '{XOR_, ADC, SUB, XOR_, ADC, SBC, SBC};
        logic [31:0] a   [7] = '{32'd5, 32'd0, 32'd5, 32'd5, 32'd0, 32'd5, 32'd5};
        logic [31:0] b   [7] = '{32'd5, 32'd0, 32'd3, 32'd5, 32'd0, 32'd3, 32'd3};
        logic [35:0] exp [7] = '{{32'd0, 4'b1000}, {32'd0, 4'b1000}, {32'd2, 4'b0100},
                                 {32'd0, 4'b1000}, {32'd1, 4'b0000}, {32'd1, 4'b0100},
                                 {32'd2, 4'b0100}};
        for (int i = 0; i < 7; i++) begin
            push_op(s[i], a[i], b[i]);
            tests++;
            if ({res, z, c, v, n} !== exp[i]) begin
                fails++;
                $display("FAIL carry_%0d got %h/%b%b%b%b want %h", i, res, z, c, v, n, exp[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        @(negedge elk);
        sel = ADD; opA = 32'd1; opB = 32'd1; in_valid = 1'b1;
        @(posedge elk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_rdy_after_a got %b want 1", in_ready);
        end
        @(negedge elk);
        sel = ADD; opA = 32'd2; opB = 32'd2;
        @(posedge elk); #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_rdy_after_b got %b want 0", in_ready);
        end
        @(negedge elk);
        sel = OR_; opA = 32'd8; opB = 32'd1;
        @(posedge elk); #1;
        tests++;
        if ({in_ready, out_valid, res} !== {1'b0, 1'b1, 32'd2}) begin
            fails++;
            $display("FAIL bp_hold got rdy=%b vld=%b res=%h want rdy=0 vld=1 res=00000002",
                     in_ready, out_valid, res);
        end
        @(negedge elk);
        out_ready = 1'b1;
        @(posedge elk); #1;
        tests++;
        if ({in_ready, res, z, c, v, n} !== {1'b1, 32'd4, 4'b0000}) begin
            fails++;
            $display("FAIL bp_pop_a got rdy=%b %h/%b%b%b%b want rdy=1 00000004/0000",
                     in_ready, res, z, c, v, n);
        end
        @(posedge elk); #1;
        tests++;
        if ({out_valid, res, z, c, v, n} !== {1'b1, 32'd9, 4'b0000}) begin
            fails++;
            $display("FAIL bp_pop_b got vld=%b %h/%b%b%b%b want vld=1 00000009/0000",
                     out_valid, res, z, c, v, n);
        end
        @(negedge elk);
        in_valid = 1'b0;
        @(posedge elk); #1;
        out_ready = 1'b0;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL bp_drain got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push_op(ADD, 32'hFFFF_FFFF, 32'h1);
        push_op(ADD, 32'hFFFF_FFFF, 32'h1);
        tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            fails++;
            $display("FAIL rst_mid_full got vld=%b rdy=%b want vld=1 rdy=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, res, z, c, v, n} !== {1'b1 ^ 1'b1, 1'b1, 36'h0}) begin
            fails++;
            $display("FAIL rst_mid_async got vld=%b rdy=%b %h/%b%b%b%b want vld=0 rdy=1 zero",
                     out_valid, in_ready, res, z, c, v, n);
        end
        @(negedge elk);
        rst_n = 1'b1;
        repeat (2) @(posedge elk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_empty got vld=%b want 0", out_valid);
        end
        push_op(ADC, 32'h0, 32'h0);
        tests++;
        if ({res, z, c, v, n} !== {32'h0, 4'b1000}) begin
            fails++;
            $display("FAIL rst_mid_cy got %h/%b%b%b%b want 00000000/1000", res, z, c, v, n);
        end
        pop_one();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 3'b000;
        opA       = '0;
        opB       = '0;
        test_reset();
        test_sub();
        test_overflow();
        test_logic();
        test_back_to_back();
        test_carry_hold();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
